// File: rtl/regfile32.sv
// 32-entry register file: two combinational read ports, one write port,
// hard-wired zero register, optional write-to-read forwarding.
module regfile32 #(
  parameter int DATA_W = 32,
  parameter int BYPASS = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              RegWrite,
  input  logic [4:0]        WriteAddr,
  input  logic [DATA_W-1:0] WriteData,
  input  logic [4:0]        ReadAddr1,
  input  logic [4:0]        ReadAddr2,
  output logic [DATA_W-1:0] ReadData1,
  output logic [DATA_W-1:0] ReadData2,
  output logic [31:0]       WrOneHot
);

  logic [DATA_W-1:0] regs_q [32];
  logic [31:0]       strobe_d;
  logic [31:0]       wr_onehot_q;

  // Bit 0 is cleared here so register 0 and the trace never see a write.
  always_comb begin
    strobe_d = '0;
    if (RegWrite) strobe_d[WriteAddr] = 1'b1;
    strobe_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) regs_q[i] <= '0;
      wr_onehot_q <= '0;
    end else begin
      for (int i = 1; i < 32; i++) begin
        if (strobe_d[i]) regs_q[i] <= WriteData;
      end
      wr_onehot_q <= strobe_d;
    end
  end

  // Forwarding reuses the strobe, so it is already gated by RegWrite and never hits index 0.
  always_comb begin
    ReadData1 = '0;
    if (ReadAddr1 != 5'd0) begin
      if ((BYPASS != 0) && strobe_d[ReadAddr1]) ReadData1 = WriteData;
      else                                      ReadData1 = regs_q[ReadAddr1];
    end
  end

  always_comb begin
    ReadData2 = '0;
    if (ReadAddr2 != 5'd0) begin
      if ((BYPASS != 0) && strobe_d[ReadAddr2]) ReadData2 = WriteData;
      else                                      ReadData2 = regs_q[ReadAddr2];
    end
  end

  assign WrOneHot = wr_onehot_q;

endmodule

// File: tb/tb_regfile32.sv
// Bench for regfile32: forwarding and non-forwarding instances share stimulus and
// are checked every cycle against an array model plus directed literal checks.
module tb_regfile32;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         RegWrite = 1'b0;
  logic [4:0]   WriteAddr = '0;
  logic [W-1:0] WriteData = '0;
  logic [4:0]   ReadAddr1 = '0;
  logic [4:0]   ReadAddr2 = '0;
  logic [W-1:0] rd1_b, rd2_b, rd1_n, rd2_n;
  logic [31:0]  oh_b, oh_n;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] mem [32];
  logic [31:0]  exp_q [$];
  bit           model_valid = 1'b0;

  // Clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    errors++;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  regfile32 #(.DATA_W(W), .BYPASS(1)) dut_b (
    .clk(clk), .reset(reset), .RegWrite(RegWrite), .WriteAddr(WriteAddr),
    .WriteData(WriteData), .ReadAddr1(ReadAddr1), .ReadAddr2(ReadAddr2),
    .ReadData1(rd1_b), .ReadData2(rd2_b), .WrOneHot(oh_b)
  );

  regfile32 #(.DATA_W(W), .BYPASS(0)) dut_n (
    .clk(clk), .reset(reset), .RegWrite(RegWrite), .WriteAddr(WriteAddr),
    .WriteData(WriteData), .ReadAddr1(ReadAddr1), .ReadAddr2(ReadAddr2),
    .ReadData1(rd1_n), .ReadData2(rd2_n), .WrOneHot(oh_n)
  );

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: array of register contents, expected trace queued per edge
  always @(posedge clk) begin
    model_valid = 1'b1;
    if (reset) begin
      for (int i = 0; i < 32; i++) mem[i] = '0;
      exp_q.push_back(32'd0);
    end else if (RegWrite && WriteAddr != 5'd0) begin
      mem[WriteAddr] = WriteData;
      exp_q.push_back(32'd1 << WriteAddr);
    end else begin
      exp_q.push_back(32'd0);
    end
  end

  function automatic logic [W-1:0] exp_rd(input logic [4:0] a, input bit fwd);
    if (a == 5'd0) return '0;
    if (fwd && RegWrite && WriteAddr == a) return WriteData;
    return mem[a];
  endfunction

  // Scoreboard: every negedge, all outputs of both instances
  always @(negedge clk) begin
    if (model_valid) begin
      logic [31:0] e;
      check("rd1_fwd", rd1_b, exp_rd(ReadAddr1, 1'b1));
      check("rd2_fwd", rd2_b, exp_rd(ReadAddr2, 1'b1));
      check("rd1_nofwd", rd1_n, exp_rd(ReadAddr1, 1'b0));
      check("rd2_nofwd", rd2_n, exp_rd(ReadAddr2, 1'b0));
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("onehot_fwd", oh_b, e);
        check("onehot_nofwd", oh_n, e);
      end else begin
        check("onehot_queue_empty", 32'd1, 32'd0);
      end
    end
  end

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_write(input logic we, input logic [4:0] wa, input logic [W-1:0] wd);
    RegWrite  = we;
    WriteAddr = wa;
    WriteData = wd;
  endtask

  initial begin
    // Reset held for two edges, then sweep read port 1
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    for (int a = 0; a < 32; a++) begin
      ReadAddr1 = a[4:0];
      #2;
      check("reset_sweep_rd1", rd1_b, '0);
      check("reset_onehot", oh_b, '0);
      tick();
    end

    // Write 1..31, trace one edge after each write
    for (int k = 1; k < 32; k++) begin
      drive_write(1'b1, k[4:0], 32'hA5A5_0000 + k);
      tick();
      check("write_onehot", oh_b, 32'd1 << k);
    end
    drive_write(1'b0, 5'd0, '0);
    for (int k = 1; k < 32; k++) begin
      ReadAddr1 = k[4:0];
      ReadAddr2 = k[4:0];
      #2;
      check("readback_rd1", rd1_b, 32'hA5A5_0000 + k);
      check("readback_rd2", rd2_n, 32'hA5A5_0000 + k);
      tick();
    end

    // Register 0 discards writes
    drive_write(1'b1, 5'd0, 32'hFFFF_FFFF);
    ReadAddr1 = 5'd0;
    tick();
    drive_write(1'b0, 5'd0, '0);
    #2;
    check("zero_reg_rd1", rd1_b, '0);
    check("zero_reg_onehot", oh_b, '0);
    tick();

    // Forwarding vs. no forwarding
    drive_write(1'b1, 5'd5, 32'h1111_1111);
    tick();
    drive_write(1'b1, 5'd5, 32'h2222_2222);
    ReadAddr2 = 5'd5;
    #2;
    check("bypass_fwd", rd2_b, 32'h2222_2222);
    check("bypass_nofwd_old", rd2_n, 32'h1111_1111);
    tick();
    drive_write(1'b0, 5'd0, '0);
    #2;
    check("bypass_nofwd_after_edge", rd2_n, 32'h2222_2222);
    tick();

    // Reset wins over a same-edge write
    drive_write(1'b1, 5'd7, 32'hDEAD_BEEF);
    tick();
    reset = 1'b1;
    drive_write(1'b1, 5'd9, 32'h1234_5678);
    tick();
    reset = 1'b0;
    drive_write(1'b0, 5'd0, '0);
    ReadAddr1 = 5'd7;
    ReadAddr2 = 5'd9;
    #2;
    check("collision_reg7", rd1_b, '0);
    check("collision_reg9", rd2_b, '0);
    check("collision_onehot", oh_b, '0);
    tick();

    // Known fill, then 64 cycles of disabled writes with random address/data
    for (int k = 1; k < 32; k++) begin
      drive_write(1'b1, k[4:0], 32'h1000_0000 | k);
      tick();
    end
    for (int c = 0; c < 64; c++) begin
      drive_write(1'b0, 5'($urandom_range(0, 31)), $urandom);
      ReadAddr1 = 5'($urandom_range(0, 31));
      ReadAddr2 = 5'($urandom_range(0, 31));
      tick();
    end
    drive_write(1'b0, 5'd0, '0);
    for (int k = 0; k < 32; k++) begin
      ReadAddr1 = k[4:0];
      ReadAddr2 = 5'(31 - k);
      #2;
      check("disabled_hold_rd1", rd1_n, (k == 0) ? 32'd0 : (32'h1000_0000 | k));
      check("disabled_hold_rd2", rd2_b, (k == 31) ? 32'd0 : (32'h1000_0000 | (31 - k)));
      tick();
    end

    // Randomized traffic, occasional reset, frequent read/write address collisions
    for (int c = 0; c < 2000; c++) begin
      reset    = ($urandom_range(0, 63) == 0);
      RegWrite = $urandom_range(0, 1);
      WriteAddr = 5'($urandom_range(0, 31));
      WriteData = $urandom;
      ReadAddr1 = ($urandom_range(0, 3) == 0) ? WriteAddr : 5'($urandom_range(0, 31));
      ReadAddr2 = ($urandom_range(0, 3) == 0) ? ReadAddr1 : 5'($urandom_range(0, 31));
      tick();
    end
    reset = 1'b0;
    drive_write(1'b0, 5'd0, '0);
    tick();
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
